// File: rtl/cellrv32_cpu_cp_muldiv_gen2_if.sv
// Handshake/operand bundle between the CPU core and the mul/div co-processor.
//   start_i  : launch an operation (sampled only while the unit is idle)
//   funct3_i : operation select (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
//   trap_i   : abort a running iterative operation
//   rs1_i    : multiplicand / dividend
//   rs2_i    : multiplier / divisor
//   res_o    : result, forced to zero except while valid_o is high
//   valid_o  : one-cycle result strobe
//   busy_o   : unit is not idle
interface cellrv32_cpu_cp_muldiv_gen2_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      funct3_i;
  logic            trap_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic [XLEN-1:0] res_o;
  logic            valid_o;
  logic            busy_o;

  modport master (output start_i, funct3_i, trap_i, rs1_i, rs2_i,
                  input  res_o, valid_o, busy_o);
  modport slave  (input  start_i, funct3_i, trap_i, rs1_i, rs2_i,
                  output res_o, valid_o, busy_o);
endinterface

// File: rtl/cellrv32_cpu_cp_muldiv_gen2.sv
// RISC-V M-extension co-processor: multiply (single-cycle parallel or serial
// radix-4 Booth) and restoring divide with DIV_STEP quotient bits per cycle.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : slave side of cellrv32_cpu_cp_muldiv_gen2_if (start/funct3/trap/
//           rs1/rs2 in, res/valid/busy out)
module cellrv32_cpu_cp_muldiv_gen2 #(
  parameter int XLEN        = 32,
  parameter int FAST_MUL_EN = 1,
  parameter int DIVISION_EN = 1,
  parameter int DIV_STEP    = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  cellrv32_cpu_cp_muldiv_gen2_if.slave  bus
);

  localparam int CW = $clog2(XLEN);
  localparam int W2 = 2 * XLEN;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [W2-1:0]   acc_q, acc_d, mcand_q, mcand_d;
  logic [XLEN-1:0] mplr_q, mplr_d;
  logic            mprev_q, mprev_d;
  logic [XLEN-1:0] quo_q, quo_d, rmd_q, rmd_d, dvs_q, dvs_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            valid_q, valid_d;

  function automatic logic sgn1(input logic [2:0] f);
    return (f == 3'b001) || (f == 3'b010) || (f[2] && !f[0]);
  endfunction

  function automatic logic sgn2(input logic [2:0] f);
    return (f == 3'b001) || (f[2] && !f[0]);
  endfunction

  // Sign- or zero-extension to the full product width.
  function automatic logic [W2-1:0] ext2(input logic [XLEN-1:0] v, input logic s);
    return {{XLEN{s & v[XLEN-1]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic s);
    return (s && v[XLEN-1]) ? ('0 - v) : v;
  endfunction

  // Divide-by-zero and signed overflow skip the iterative core.
  function automatic logic div_special(input logic [2:0] f,
                                       input logic [XLEN-1:0] a, b);
    return (b == '0) || (!f[0] && (a == SMIN) && (b == '1));
  endfunction

  // One radix-4 Booth digit {b[2k+1], b[2k], b[2k-1]} applied to the accumulator.
  function automatic logic [W2-1:0] booth_add(input logic [W2-1:0] acc, m,
                                               input logic [2:0] bits);
    case (bits)
      3'b001, 3'b010: return acc + m;
      3'b011:         return acc + (m << 1);
      3'b100:         return acc - (m << 1);
      3'b101, 3'b110: return acc - m;
      default:        return acc;
    endcase
  endfunction

  logic                 start_direct;
  logic [W2-1:0]        booth_init;
  logic signed [W2-1:0] fast_a, fast_b, fast_prod;
  logic [W2-1:0]        prod;
  logic [XLEN:0]        div_t;
  logic [XLEN-1:0]      div_r, div_q, quo_c, rem_c, done_res;
  logic                 neg_q, neg_r;

  assign start_direct = bus.funct3_i[2]
                      ? ((DIVISION_EN == 0) || div_special(bus.funct3_i, bus.rs1_i, bus.rs2_i))
                      : (FAST_MUL_EN != 0);

  // Zero-extended rs2 carries one extra Booth digit above the top of the
  // operand; it equals rs2[XLEN-1] and is folded into the initial accumulator.
  assign booth_init = (!sgn2(bus.funct3_i) && bus.rs2_i[XLEN-1])
                    ? (ext2(bus.rs1_i, sgn1(bus.funct3_i)) << XLEN) : '0;

  assign fast_a    = signed'(ext2(rs1_q, sgn1(op_q)));
  assign fast_b    = signed'(ext2(rs2_q, sgn2(op_q)));
  assign fast_prod = fast_a * fast_b;

  // DIV_STEP restoring-division steps per cycle.
  always_comb begin
    div_r = rmd_q;
    div_q = quo_q;
    div_t = '0;
    for (int i = 0; i < DIV_STEP; i++) begin
      div_t = {div_r, div_q[XLEN-1]};
      div_q = {div_q[XLEN-2:0], 1'b0};
      if (div_t >= {1'b0, dvs_q}) begin
        div_t    = div_t - {1'b0, dvs_q};
        div_q[0] = 1'b1;
      end
      div_r = div_t[XLEN-1:0];
    end
  end

  always_comb begin
    prod  = (FAST_MUL_EN != 0) ? fast_prod : acc_q;
    neg_q = !op_q[0] && (rs1_q[XLEN-1] ^ rs2_q[XLEN-1]);
    neg_r = !op_q[0] && rs1_q[XLEN-1];
    quo_c = neg_q ? ('0 - quo_q) : quo_q;
    rem_c = neg_r ? ('0 - rmd_q) : rmd_q;
    if (!op_q[2])
      done_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[W2-1:XLEN];
    else if (DIVISION_EN == 0)
      done_res = '0;
    else if (rs2_q == '0)
      done_res = op_q[1] ? rs1_q : '1;
    else if (div_special(op_q, rs1_q, rs2_q))
      done_res = op_q[1] ? '0 : SMIN;
    else
      done_res = op_q[1] ? rem_c : quo_c;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    mprev_d = mprev_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dvs_d   = dvs_q;
    res_d   = '0;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          op_d  = bus.funct3_i;
          rs1_d = bus.rs1_i;
          rs2_d = bus.rs2_i;
          if (start_direct) begin
            state_d = S_DONE;
          end else begin
            state_d = S_BUSY;
            if (bus.funct3_i[2]) begin
              cnt_d = CW'(XLEN / DIV_STEP - 1);
              quo_d = mag(bus.rs1_i, sgn1(bus.funct3_i));
              dvs_d = mag(bus.rs2_i, sgn2(bus.funct3_i));
              rmd_d = '0;
            end else begin
              cnt_d   = CW'(XLEN / 2 - 1);
              acc_d   = booth_init;
              mcand_d = ext2(bus.rs1_i, sgn1(bus.funct3_i));
              mplr_d  = bus.rs2_i;
              mprev_d = 1'b0;
            end
          end
        end
      end
      S_BUSY: begin
        if (bus.trap_i) begin
          state_d = S_IDLE;
        end else begin
          if (op_q[2]) begin
            quo_d = div_q;
            rmd_d = div_r;
          end else begin
            acc_d   = booth_add(acc_q, mcand_q, {mplr_q[1:0], mprev_q});
            mcand_d = mcand_q << 2;
            mplr_d  = mplr_q >> 2;
            mprev_d = mplr_q[1];
          end
          if (cnt_q == '0) state_d = S_DONE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        valid_d = 1'b1;
        res_d   = done_res;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      mprev_q <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      mprev_q <= mprev_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  assign bus.res_o   = res_q;
  assign bus.valid_o = valid_q;
  assign bus.busy_o  = (state_q != S_IDLE);

endmodule
